reduce4_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 4-input OR cell.
- Reduces NUM_IN lanes of DATA_W bits, bitwise across lanes, to one DATA_W result.
- Supports a run-time selected operation: OR, AND, XOR or NOR.
- Built as a tree of registered 4-input reduction stages, with valid/ready handshakes on both sides.

---
 rtl/reduce_pkg.sv | 57 +++++
 rtl/reduce4_stage.sv | 68 ++++++
 rtl/reduce4_pipe.sv | 107 ++++++++++
 tb/tb_reduce4_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined lane-reduction tree.
// Sizing helpers are constant functions, so they are evaluated at elaboration.
package reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    localparam int MIN_IN = 2;
    localparam int MAX_IN = 64;
    localparam int MIN_W  = 1;
    localparam int MAX_W  = 32;

    // Neutral element of the operation, right-aligned in a 32-bit word.
    function automatic logic [31:0] identity(input op_t op, input int width);
        logic [31:0] ones;
        ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (op == OP_AND) ? ones : 32'd0;
    endfunction

    // Number of 4:1 levels needed to fold n lanes down to one.
    function automatic int levels_for(input int n);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        while (span < n) begin
            span = span * 4;
            lv   = lv + 1;
        end
        return lv;
    endfunction

    // Lanes present at the input of level lvl (level 0 sees the n input lanes).
    function automatic int lanes_at(input int n, input int lvl);
        int lanes;
        lanes = n;
        for (int i = 0; i < lvl; i++) begin
            lanes = (lanes + 3) / 4;
        end
        return lanes;
    endfunction

    // Lane offset of level lvl's output inside the flattened inter-level bus.
    function automatic int seg_off(input int n, input int lvl);
        int sum;
        sum = 0;
        for (int k = 0; k < lvl; k++) begin
            sum = sum + lanes_at(n, k + 1);
        end
        return sum;
    endfunction

endpackage

// File: rtl/reduce4_stage.sv
// One registered level of the reduction tree: folds each group of four lanes
// into one, padding the ragged last group with the operation's identity.
module reduce4_stage
    import reduce_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int N_GRP  = 1,
    parameter int N_IN   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      adv,
    input  logic                      in_valid,
    input  op_t                       in_op,
    input  logic [N_IN*DATA_W-1:0]    in_data,
    output logic                      out_valid,
    output op_t                       out_op,
    output logic [N_GRP*DATA_W-1:0]   out_data
);

    op_t                      red_op;
    logic [DATA_W-1:0]        lanes [N_GRP*4];
    logic [DATA_W-1:0]        acc;
    logic [N_GRP*DATA_W-1:0]  red;

    // NOR travels through the tree as OR; the inversion happens once at the output.
    always_comb begin
        red_op = (in_op == OP_NOR) ? OP_OR : in_op;
    end

    for (genvar gl = 0; gl < N_GRP * 4; gl++) begin : g_lane
        if (gl < N_IN) begin : g_real
            assign lanes[gl] = in_data[gl*DATA_W +: DATA_W];
        end else begin : g_pad
            assign lanes[gl] = DATA_W'(identity(red_op, DATA_W));
        end
    end

    always_comb begin
        red = '0;
        acc = '0;
        for (int g = 0; g < N_GRP; g++) begin
            acc = lanes[g*4];
            for (int j = 1; j < 4; j++) begin
                case (red_op)
                    OP_AND:  acc = acc & lanes[g*4+j];
                    OP_XOR:  acc = acc ^ lanes[g*4+j];
                    default: acc = acc | lanes[g*4+j];
                endcase
            end
            red[g*DATA_W +: DATA_W] = acc;
        end
    end

    // Bubbles are held like real words, so the whole tree moves in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= OP_OR;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_op    <= in_op;
            out_data  <= red;
        end
    end

endmodule

// File: rtl/reduce4_pipe.sv
// Pipelined bitwise OR/AND/XOR/NOR reduction of NUM_IN lanes built from 4:1 stages.
// Optional REDUCE_STICKY_EN adds sticky_clr/sticky_res, an accumulated OR of accepted results.
module reduce4_pipe
    import reduce_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_op,
`ifdef REDUCE_STICKY_EN
    input  logic                      sticky_clr,
    output logic [DATA_W-1:0]         sticky_res,
`endif
    output logic [DATA_W-1:0]         out_res
);

    localparam int LEVELS = levels_for(NUM_IN);
    localparam int TOT_W  = seg_off(NUM_IN, LEVELS) * DATA_W;

    if (NUM_IN < MIN_IN || NUM_IN > MAX_IN) begin : g_bad_num_in
        $error("reduce4_pipe: NUM_IN=%0d outside %0d..%0d", NUM_IN, MIN_IN, MAX_IN);
    end
    if (DATA_W < MIN_W || DATA_W > MAX_W) begin : g_bad_data_w
        $error("reduce4_pipe: DATA_W=%0d outside %0d..%0d", DATA_W, MIN_W, MAX_W);
    end

    logic                 adv;
    logic [TOT_W-1:0]     chain;
    logic [LEVELS-1:0]    v_chain;
    op_t                  op_chain [LEVELS];
    logic [DATA_W-1:0]    tree_res;

    // Handshake: a word transfers on a side only in a cycle where valid && ready
    // are both high at the rising edge. Input ready is the global advance, which
    // looks only at the output side, so it never depends on in_valid. A presented
    // output keeps its data and op unchanged until it is accepted.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int LIN  = lanes_at(NUM_IN, l);
        localparam int LGRP = lanes_at(NUM_IN, l + 1);
        localparam int OOFF = seg_off(NUM_IN, l) * DATA_W;

        logic [LIN*DATA_W-1:0] st_in;
        logic                  st_vin;
        op_t                   st_opin;

        if (l == 0) begin : g_head
            assign st_in   = in_data;
            assign st_vin  = in_valid;
            assign st_opin = op_t'(in_op);
        end else begin : g_body
            localparam int IOFF = seg_off(NUM_IN, l - 1) * DATA_W;
            assign st_in   = chain[IOFF +: LIN*DATA_W];
            assign st_vin  = v_chain[l-1];
            assign st_opin = op_chain[l-1];
        end

        reduce4_stage #(
            .DATA_W (DATA_W),
            .N_GRP  (LGRP),
            .N_IN   (LIN)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .in_valid  (st_vin),
            .in_op     (st_opin),
            .in_data   (st_in),
            .out_valid (v_chain[l]),
            .out_op    (op_chain[l]),
            .out_data  (chain[OOFF +: LGRP*DATA_W])
        );
    end

    // The last level always narrows to a single lane at the top of the bus.
    assign tree_res  = chain[TOT_W-DATA_W +: DATA_W];
    assign out_valid = v_chain[LEVELS-1];
    assign out_op    = op_chain[LEVELS-1];
    assign out_res   = (op_chain[LEVELS-1] == OP_NOR) ? ~tree_res : tree_res;

`ifdef REDUCE_STICKY_EN
    logic out_acc;
    assign out_acc = out_valid && out_ready;

    // A clear coinciding with an acceptance restarts the history from that result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_res <= '0;
        end else if (sticky_clr) begin
            sticky_res <= out_acc ? out_res : '0;
        end else if (out_acc) begin
            sticky_res <= sticky_res | out_res;
        end
    end
`endif

endmodule

// File: tb/tb_reduce4_pipe.sv
// Bench for reduce4_pipe: three configurations (16x8, 6x4, 64x8) share one
// stimulus stream and are checked against a plain lane-by-lane fold model.
module tb_reduce4_pipe;

    localparam int NA = 16, WA = 8;
    localparam int NB = 6,  WB = 4;
    localparam int NC = 64, WC = 8;
    localparam int DW = NC * WC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic          sticky_clr;
    logic [1:0]    in_op;
    logic [DW-1:0] data_all;

    logic          ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [1:0]    oo_a, oo_b, oo_c;
    logic [WA-1:0] res_a;
    logic [WB-1:0] res_b;
    logic [WC-1:0] res_c;
`ifdef REDUCE_STICKY_EN
    logic [WA-1:0] sticky_a;
    logic [WB-1:0] sticky_b;
    logic [WC-1:0] sticky_c;
`endif

    reduce4_pipe #(.NUM_IN(NA), .DATA_W(WA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in_op(in_op),
        .in_data(data_all[NA*WA-1:0]), .out_valid(ov_a), .out_ready(out_ready), .out_op(oo_a),
`ifdef REDUCE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_res(sticky_a),
`endif
        .out_res(res_a)
    );

    reduce4_pipe #(.NUM_IN(NB), .DATA_W(WB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in_op(in_op),
        .in_data(data_all[NB*WB-1:0]), .out_valid(ov_b), .out_ready(out_ready), .out_op(oo_b),
`ifdef REDUCE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_res(sticky_b),
`endif
        .out_res(res_b)
    );

    reduce4_pipe #(.NUM_IN(NC), .DATA_W(WC)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .in_op(in_op),
        .in_data(data_all), .out_valid(ov_c), .out_ready(out_ready), .out_op(oo_c),
`ifdef REDUCE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_res(sticky_c),
`endif
        .out_res(res_c)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit lat_mode = 1'b0;

    // Entry layout: {accept cycle[31:0], op[1:0], result[7:0]}
    logic [41:0] q0[$];
    logic [41:0] q1[$];
    logic [41:0] q2[$];
    logic        prev_stall [3];
    logic [9:0]  prev_word  [3];

    function automatic int n_of(input int id);
        return (id == 0) ? NA : (id == 1) ? NB : NC;
    endfunction
    function automatic int w_of(input int id);
        return (id == 0) ? WA : (id == 1) ? WB : WC;
    endfunction
    function automatic int lv_of(input int id);
        return (id == 2) ? 3 : 2;
    endfunction
    function automatic logic ov_of(input int id);
        return (id == 0) ? ov_a : (id == 1) ? ov_b : ov_c;
    endfunction
    function automatic logic ir_of(input int id);
        return (id == 0) ? ir_a : (id == 1) ? ir_b : ir_c;
    endfunction
    function automatic logic [1:0] op_of(input int id);
        return (id == 0) ? oo_a : (id == 1) ? oo_b : oo_c;
    endfunction
    function automatic logic [7:0] res_of(input int id);
        return (id == 0) ? res_a : (id == 1) ? {4'h0, res_b} : res_c;
    endfunction

    // Reference: fold every real lane in order, then invert for NOR.
    function automatic logic [7:0] ref_red(input logic [1:0] op, input int n, input int w,
                                           input logic [DW-1:0] d);
        logic [7:0] mask, lane, acc;
        mask = 8'((1 << w) - 1);
        acc  = 8'h00;
        for (int k = 0; k < n; k++) begin
            lane = 8'(d >> (k * w)) & mask;
            if (k == 0) acc = lane;
            else if (op == 2'b01) acc = acc & lane;
            else if (op == 2'b10) acc = acc ^ lane;
            else acc = acc | lane;
        end
        if (op == 2'b11) acc = ~acc & mask;
        return acc;
    endfunction

    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, id, obs, exp);
        end
    endtask

    task automatic q_push(input int id, input logic [41:0] v);
        case (id)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic q_pop(input int id, output logic [41:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        case (id)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int q_size(input int id);
        return (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    endfunction

    task automatic clear_model();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int id = 0; id < 3; id++) prev_stall[id] = 1'b0;
    endtask

    // One clock: sample and score at negedge+1, then let the rising edge happen.
    task automatic step();
        logic [41:0] e;
        bit          ok;
        @(negedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            chk("in_ready", id, 32'(ir_of(id)), 32'(!ov_of(id) || out_ready));
            if (prev_stall[id]) begin
                chk("hold_valid", id, 32'(ov_of(id)), 32'd1);
                chk("hold_word", id, 32'({op_of(id), res_of(id)}), 32'(prev_word[id]));
            end
            if (ov_of(id) && out_ready) begin
                q_pop(id, e, ok);
                if (!ok) begin
                    chk("spurious_out", id, 32'(ov_of(id)), 32'd0);
                end else begin
                    chk("out_res", id, 32'(res_of(id)), 32'(e[7:0]));
                    chk("out_op", id, 32'(op_of(id)), 32'(e[9:8]));
                    if (lat_mode) chk("latency", id, 32'(cyc) - e[41:10], 32'(lv_of(id)));
                end
            end
            if (rst_n && in_valid && ir_of(id))
                q_push(id, {32'(cyc), in_op, ref_red(in_op, n_of(id), w_of(id), data_all)});
            prev_stall[id] = ov_of(id) && !out_ready;
            prev_word[id]  = {op_of(id), res_of(id)};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_data();
        for (int i = 0; i < DW / 32; i++) begin
            case ($urandom_range(0, 2))
                0: data_all[i*32 +: 32] = $urandom();
                1: data_all[i*32 +: 32] = $urandom() & $urandom() & $urandom() & $urandom();
                default: data_all[i*32 +: 32] = $urandom() | $urandom() | $urandom() | $urandom();
            endcase
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        sticky_clr = 1'b0;
        in_op      = 2'b00;
        data_all   = '0;
        clear_model();

        // Reset state
        repeat (2) step();
        for (int id = 0; id < 3; id++) begin
            chk("rst_valid", id, 32'(ov_of(id)), 32'd0);
            chk("rst_res", id, 32'(res_of(id)), 32'd0);
            chk("rst_op", id, 32'(op_of(id)), 32'd0);
        end
`ifdef REDUCE_STICKY_EN
        chk("rst_sticky", 0, 32'(sticky_a), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // Mixed ops in flight: lanes 0xFF except lane 5 = 0x0F; AND, XOR, NOR back to back
        lat_mode = 1'b1;
        data_all = '1;
        data_all[5*8 +: 8] = 8'h0F;
        in_valid = 1'b1;
        in_op = 2'b01; step();
        in_op = 2'b10; step();
        in_op = 2'b11; step();
        in_valid = 1'b0;
        repeat (5) step();

        // Identity padding: every 4-bit lane 0xA under AND
        data_all = {(DW/4){4'hA}};
        in_op    = 2'b01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();

        // Boundary single-lane patterns under OR and XOR
        for (int i = 0; i < 4; i++) begin
            data_all = '0;
            data_all[($urandom_range(0, NB - 1)) * 4] = 1'b1;
            in_op    = (i < 2) ? 2'b00 : 2'b10;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();

        // Backpressure: fill, stall three cycles with input offered, then drain
        lat_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            in_op = 2'($urandom_range(0, 3));
            step();
        end
        out_ready = 1'b0;
        repeat (3) step();
        for (int id = 0; id < 3; id++) begin
            chk("bp_in_ready", id, 32'(ir_of(id)), 32'd0);
            chk("bp_out_valid", id, 32'(ov_of(id)), 32'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (6) step();
        for (int id = 0; id < 3; id++) chk("bp_drained", id, 32'(q_size(id)), 32'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            rand_data();
            in_op     = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        for (int id = 0; id < 3; id++) chk("rand_drained", id, 32'(q_size(id)), 32'd0);

        // Reset mid-flight: two words accepted, async reset between edges
        in_valid = 1'b1;
        rand_data(); in_op = 2'b00; step();
        rand_data(); in_op = 2'b10; step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int id = 0; id < 3; id++) chk("rst_async_valid", id, 32'(ov_of(id)), 32'd0);
        clear_model();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            for (int id = 0; id < 3; id++) chk("post_rst_idle", id, 32'(ov_of(id)), 32'd0);
        end

`ifdef REDUCE_STICKY_EN
        lat_mode = 1'b1;
        chk("sticky_after_rst", 0, 32'(sticky_a), 32'd0);
        data_all = '0;
        in_op    = 2'b00;
        in_valid = 1'b1;
        data_all[7:0] = 8'h01; step();
        data_all[7:0] = 8'h04; step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("sticky_accum", 0, 32'(sticky_a), 32'h05);
        data_all[7:0] = 8'h10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sticky_clr = ov_a;
            step();
            if (sticky_clr) begin
                sticky_clr = 1'b0;
                break;
            end
        end
        chk("sticky_clr_load", 0, 32'(sticky_a), 32'h10);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        chk("sticky_clr_alone", 0, 32'(sticky_a), 32'h00);
        repeat (4) step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
